// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - hazard controller pipeline-side signal bundle
// slave: the controller; master: the pipeline datapath that feeds it hazard info.
interface pipeline_hazard_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_rs;
  logic [REG_W-1:0] ID_rt;
  logic             ID_usesRt;
  logic             ID_EX_memRead;
  logic [REG_W-1:0] ID_EX_rt;
  logic             md_start;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             md_done;
  logic             protocol_err;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  ID_rs, ID_rt, ID_usesRt, ID_EX_memRead, ID_EX_rt,
    input  md_start, branch_taken, mem_busy,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    output if_id_flush, id_ex_flush, ex_mem_flush,
    output md_done, protocol_err, stall_cycles
  );

  modport master (
    output ID_rs, ID_rt, ID_usesRt, ID_EX_memRead, ID_EX_rt,
    output md_start, branch_taken, mem_busy,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    input  if_id_flush, id_ex_flush, ex_mem_flush,
    input  md_done, protocol_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for a 5-stage pipeline
// Load-use bubbles, mul/div front-end freeze, taken-branch flush, memory-wait freeze.
module pipeline_hazard_controller #(
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_hazard_controller_if.slave  bus
);

  localparam int MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 2);
  localparam logic [REG_W-1:0]    ZERO_REG  = '0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                err_q, err_d;
  logic                load_use;

  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, md_done;

  // The ID instruction needs the loaded value before forwarding can supply it.
  assign load_use = bus.ID_EX_memRead && (bus.ID_EX_rt != ZERO_REG) &&
                    ((bus.ID_EX_rt == bus.ID_rs) ||
                     (bus.ID_usesRt && (bus.ID_EX_rt == bus.ID_rt)));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    err_d        = err_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_done      = 1'b0;

    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (bus.mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (state_q == MD_WAIT) begin
      if (md_cnt_q != '0) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        ex_mem_flush = 1'b1;
        md_cnt_d     = md_cnt_q - 1'b1;
      end else begin
        md_done = 1'b1;
        state_d = RUN;
      end
    end else if (bus.md_start) begin
      // The start cycle is the first of MD_LATENCY cycles in EX.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      ex_mem_flush = 1'b1;
      md_cnt_d     = MD_RELOAD;
      state_d      = MD_WAIT;
      if (bus.branch_taken) begin
        err_d = 1'b1;
      end
    end else if (bus.branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_write  = id_ex_write;
  assign bus.ex_mem_write = ex_mem_write;
  assign bus.mem_wb_write = mem_wb_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.md_done      = md_done;
  assign bus.protocol_err = err_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed table, corner sequences and random run vs reference model
module tb_pipeline_hazard_controller;
  localparam int LAT = 4;

  // Control vector: {pc, if_id, id_ex, ex_mem, mem_wb writes, if_id, id_ex, ex_mem flushes, md_done}
  localparam logic [8:0] RUNDEF  = 9'b11111_000_0;
  localparam logic [8:0] LOADUSE = 9'b00111_010_0;
  localparam logic [8:0] MDSTALL = 9'b00001_001_0;
  localparam logic [8:0] BRANCH  = 9'b11111_110_0;
  localparam logic [8:0] FREEZE  = 9'b00000_000_0;
  localparam logic [8:0] DONE    = 9'b11111_000_1;
  localparam logic [8:0] RESET   = 9'b00000_111_0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.REG_W(5), .CNT_W(16)) bus ();
  pipeline_hazard_controller_if #(.REG_W(5), .CNT_W(2))  bus2 ();

  pipeline_hazard_controller #(.REG_W(5), .MD_LATENCY(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  pipeline_hazard_controller #(.REG_W(5), .MD_LATENCY(LAT), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  typedef struct {
    logic       rd;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       md;
    logic       br;
    logic       busy;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mul/div tracked as "which EX cycle is it" (1..LAT).
  bit m_md, n_md;
  int m_k, n_k;
  bit m_err, n_err;
  int m_st, n_st;
  int m_max = 65535;

  function automatic vec_t mk(string nm, logic rd, int ex_rt, int rs, int rt, logic uses,
                              logic md, logic br, logic busy, logic [8:0] exp);
    vec_t v;
    v.name = nm; v.rd = rd; v.ex_rt = 5'(ex_rt); v.rs = 5'(rs); v.rt = 5'(rt);
    v.uses = uses; v.md = md; v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [8:0] dut_ctl();
    return {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write, bus.mem_wb_write,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.md_done};
  endfunction

  task automatic model_step(output logic [8:0] ctl);
    logic lu;
    lu = bus.ID_EX_memRead && (bus.ID_EX_rt != 0) &&
         ((bus.ID_EX_rt == bus.ID_rs) || (bus.ID_usesRt && (bus.ID_EX_rt == bus.ID_rt)));
    n_md = m_md; n_k = m_k; n_err = m_err; n_st = m_st;
    if (bus.mem_busy) ctl = FREEZE;
    else if (m_md) begin
      if (m_k < LAT) begin ctl = MDSTALL; n_k = m_k + 1; end
      else begin ctl = DONE; n_md = 0; end
    end else if (bus.md_start) begin
      ctl = MDSTALL; n_md = 1; n_k = 2;
      if (bus.branch_taken) n_err = 1;
    end else if (bus.branch_taken) ctl = BRANCH;
    else if (lu) ctl = LOADUSE;
    else ctl = RUNDEF;
    if (!ctl[8] && m_st < m_max) n_st = m_st + 1;
  endtask

  task automatic model_reset();
    m_md = 0; m_k = 0; m_err = 0; m_st = 0;
  endtask

  task automatic drive(input vec_t v);
    bus.ID_EX_memRead = v.rd; bus.ID_EX_rt = v.ex_rt; bus.ID_rs = v.rs; bus.ID_rt = v.rt;
    bus.ID_usesRt = v.uses; bus.md_start = v.md; bus.branch_taken = v.br; bus.mem_busy = v.busy;
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances one cycle.
  task automatic tick(input string nm, input logic [8:0] tbl_exp, input bit use_tbl);
    logic [8:0] mexp;
    @(negedge clk);
    model_step(mexp);
    chk({nm, ".ctl"}, 32'(dut_ctl()), 32'(use_tbl ? tbl_exp : mexp));
    chk({nm, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(m_st));
    chk({nm, ".protocol_err"}, 32'(bus.protocol_err), 32'(m_err));
    @(posedge clk);
    m_md = n_md; m_k = n_k; m_err = n_err; m_st = n_st;
    #1;
  endtask

  initial begin
    bus.ID_rs = '0; bus.ID_rt = '0; bus.ID_usesRt = 0; bus.ID_EX_memRead = 0; bus.ID_EX_rt = '0;
    bus.md_start = 0; bus.branch_taken = 0; bus.mem_busy = 0;
    bus2.ID_rs = '0; bus2.ID_rt = '0; bus2.ID_usesRt = 0; bus2.ID_EX_memRead = 0; bus2.ID_EX_rt = '0;
    bus2.md_start = 0; bus2.branch_taken = 0; bus2.mem_busy = 0;
    model_reset();

    tbl.push_back(mk("lu_rs5",      1, 5, 5, 0, 0, 0, 0, 0, LOADUSE));
    tbl.push_back(mk("lu_cleared",  0, 5, 5, 0, 0, 0, 0, 0, RUNDEF));
    tbl.push_back(mk("lu_r0",       1, 0, 0, 0, 1, 0, 0, 0, RUNDEF));
    tbl.push_back(mk("lu_rt_unused",1, 7, 3, 7, 0, 0, 0, 0, RUNDEF));
    tbl.push_back(mk("lu_rt_used",  1, 7, 3, 7, 1, 0, 0, 0, LOADUSE));
    tbl.push_back(mk("br_over_lu",  1, 9, 9, 0, 0, 0, 1, 0, BRANCH));
    tbl.push_back(mk("md1",         0, 0, 0, 0, 0, 1, 0, 0, MDSTALL));
    tbl.push_back(mk("md2",         0, 0, 0, 0, 0, 1, 0, 0, MDSTALL));
    tbl.push_back(mk("md3",         0, 0, 0, 0, 0, 1, 1, 0, MDSTALL));
    tbl.push_back(mk("md_done",     0, 0, 0, 0, 0, 1, 0, 0, DONE));
    tbl.push_back(mk("md_after",    0, 0, 0, 0, 0, 0, 0, 0, RUNDEF));
    tbl.push_back(mk("mb_md1",      0, 0, 0, 0, 0, 1, 0, 0, MDSTALL));
    tbl.push_back(mk("mb_md2",      0, 0, 0, 0, 0, 0, 0, 0, MDSTALL));
    tbl.push_back(mk("mb_frz1",     0, 0, 0, 0, 0, 0, 0, 1, FREEZE));
    tbl.push_back(mk("mb_frz2",     0, 0, 0, 0, 0, 0, 0, 1, FREEZE));
    tbl.push_back(mk("mb_md3",      0, 0, 0, 0, 0, 0, 0, 0, MDSTALL));
    tbl.push_back(mk("mb_done",     0, 0, 0, 0, 0, 0, 0, 0, DONE));
    tbl.push_back(mk("mb_run_lu",   1, 4, 4, 0, 0, 0, 1, 1, FREEZE));
    tbl.push_back(mk("err_md1",     0, 0, 0, 0, 0, 1, 1, 0, MDSTALL));
    tbl.push_back(mk("err_md2",     0, 0, 0, 0, 0, 0, 0, 0, MDSTALL));
    tbl.push_back(mk("err_md3",     0, 0, 0, 0, 0, 0, 0, 0, MDSTALL));
    tbl.push_back(mk("err_done",    0, 0, 0, 0, 0, 0, 0, 0, DONE));
    tbl.push_back(mk("err_sticky",  0, 0, 0, 0, 0, 0, 0, 0, RUNDEF));

    #1;
    chk("reset.ctl", 32'(dut_ctl()), 32'(RESET));
    chk("reset.stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("reset.protocol_err", 32'(bus.protocol_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick(tbl[i].name, tbl[i].exp, 1'b1);
    end
    chk("table.stall_total", 32'(bus.stall_cycles), 32'd14);

    // Asynchronous reset in the middle of a mul/div aborts it without md_done.
    drive(mk("rst_md", 0, 0, 0, 0, 0, 1, 0, 0, MDSTALL));
    tick("rst_md1", MDSTALL, 1'b1);
    bus.md_start = 0;
    tick("rst_md2", MDSTALL, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.ctl", 32'(dut_ctl()), 32'(RESET));
    chk("rst_mid.stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("rst_mid.protocol_err", 32'(bus.protocol_err), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick("post_rst_idle", RUNDEF, 1'b1);

    // Narrow counter saturates at 3.
    chk("sat.start", 32'(bus2.stall_cycles), 32'd0);
    bus2.mem_busy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk("sat.count", 32'(bus2.stall_cycles), 32'((i < 3) ? i : 3));
    end
    bus2.mem_busy = 1'b0;
    // The main instance sat idle in RUN meanwhile; model state is unchanged.

    for (int i = 0; i < 400; i++) begin
      bus.ID_rs         = 5'($urandom_range(0, 3));
      bus.ID_rt         = 5'($urandom_range(0, 3));
      bus.ID_EX_rt      = 5'($urandom_range(0, 3));
      bus.ID_EX_memRead = ($urandom_range(0, 1) == 1);
      bus.ID_usesRt     = ($urandom_range(0, 1) == 1);
      bus.md_start      = ($urandom_range(0, 7) == 0);
      bus.branch_taken  = ($urandom_range(0, 4) == 0);
      bus.mem_busy      = ($urandom_range(0, 7) == 0);
      tick("random", RUNDEF, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
